// File: rtl/contador_5bits_decrescente.sv
// Synchronous down counter with parallel load, programmable reload value and a
// registered one-cycle borrow pulse on each 0 -> reload wrap.
module contador_5bits_decrescente #(
  parameter int unsigned            WIDTH = 5,
  parameter logic [WIDTH-1:0]       INIT  = 5'd31
) (
  input  logic             clk_input,
  input  logic             clear_input,
  input  logic             enable_input,
  input  logic             load_input,
  input  logic [WIDTH-1:0] load_value_input,
  output logic [WIDTH-1:0] count_output,
  output logic             zero_output,
  output logic             borrow_output
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_reg;
  logic             borrow_reg;
  logic             count_is_zero;

  assign count_is_zero = (count_reg == '0);

  // Priority: clear, load, enable, hold. Borrow is only set by an enabled wrap,
  // so every other branch clears it and the pulse lasts one cycle.
  always_ff @(posedge clk_input) begin
    if (clear_input) begin
      count_reg  <= INIT;
      reload_reg <= INIT;
      borrow_reg <= 1'b0;
    end else if (load_input) begin
      count_reg  <= load_value_input;
      reload_reg <= load_value_input;
      borrow_reg <= 1'b0;
    end else if (enable_input) begin
      if (count_is_zero) begin
        count_reg  <= reload_reg;
        borrow_reg <= 1'b1;
      end else begin
        count_reg  <= count_reg - WIDTH'(1);
        borrow_reg <= 1'b0;
      end
    end else begin
      borrow_reg <= 1'b0;
    end
  end

  assign count_output  = count_reg;
  assign zero_output   = count_is_zero;
  assign borrow_output = borrow_reg;

endmodule

// File: tb/tb_contador_5bits_decrescente.sv
// Directed self-checking bench for the 5-bit down counter: reset, free-run wrap,
// load, priority, zero reload and mid-count clear.
module tb_contador_5bits_decrescente;

  logic       clk_input = 1'b0;
  logic       clear_input = 1'b0;
  logic       enable_input = 1'b0;
  logic       load_input = 1'b0;
  logic [4:0] load_value_input = '0;
  logic [4:0] count_output;
  logic       zero_output;
  logic       borrow_output;

  int checks = 0;
  int errors = 0;

  contador_5bits_decrescente #(.WIDTH(5), .INIT(5'd31)) dut (
    .clk_input        (clk_input),
    .clear_input      (clear_input),
    .enable_input     (enable_input),
    .load_input       (load_input),
    .load_value_input (load_value_input),
    .count_output     (count_output),
    .zero_output      (zero_output),
    .borrow_output    (borrow_output)
  );

  always #5 clk_input = ~clk_input;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk_input);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cnt, input int zero, input int brw);
    chk({tag, ".count"},  int'(count_output),  cnt);
    chk({tag, ".zero"},   int'(zero_output),   zero);
    chk({tag, ".borrow"}, int'(borrow_output), brw);
  endtask

  initial begin
    int exp_cnt;
    int exp_brw;

    // Reset with enable high: clear wins
    clear_input = 1'b1; enable_input = 1'b1;
    step();
    chk_all("reset", 31, 0, 0);
    clear_input = 1'b0;

    // Free-run: 30..0, wrap to 31 with borrow, then 30
    for (int i = 0; i < 33; i++) begin
      step();
      if (i < 31)       begin exp_cnt = 30 - i; exp_brw = 0; end
      else if (i == 31) begin exp_cnt = 31;     exp_brw = 1; end
      else              begin exp_cnt = 30;     exp_brw = 0; end
      chk_all($sformatf("free%0d", i), exp_cnt, (exp_cnt == 0) ? 1 : 0, exp_brw);
    end

    // Load 5, then count 4..0, wrap to 5 with borrow
    enable_input = 1'b0; load_input = 1'b1; load_value_input = 5'd5;
    step();
    chk_all("load5", 5, 0, 0);
    load_input = 1'b0; enable_input = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_cnt = (i < 5) ? 4 - i : 5;
      chk_all($sformatf("run5_%0d", i), exp_cnt, (exp_cnt == 0) ? 1 : 0, (i == 5) ? 1 : 0);
    end
    enable_input = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("hold%0d", i), 5, 0, 0);
    end

    // Priority: bring count to 0, then load beats wrap
    enable_input = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_all("pre_prio", 0, 1, 0);
    load_input = 1'b1; load_value_input = 5'd9;
    step();
    chk_all("load_vs_wrap", 9, 0, 0);
    clear_input = 1'b1;
    step();
    chk_all("clear_vs_load", 31, 0, 0);
    clear_input = 1'b0;

    // Degenerate reload of 0: load with enable high gives 0 and no borrow
    load_value_input = 5'd0;
    step();
    chk_all("load0", 0, 1, 0);
    load_input = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("rel0_%0d", i), 0, 1, 1);
    end

    // Mid-count clear: load 20, run to 12, clear, reload must become 31
    load_input = 1'b1; load_value_input = 5'd20;
    step();
    chk_all("load20", 20, 0, 0);
    load_input = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk_all("at12", 12, 0, 0);
    clear_input = 1'b1;
    step();
    chk_all("midclear", 31, 0, 0);
    clear_input = 1'b0;
    for (int i = 0; i < 31; i++) step();
    chk_all("mid_to0", 0, 1, 0);
    step();
    chk_all("mid_wrap", 31, 0, 1);
    enable_input = 1'b0;
    step();
    chk_all("mid_hold", 31, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
